// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding host request -> APB SETUP/ACCESS initiator.
// Decodes the slave slot from addr[15:12] within a 64 KiB window at BASE_ADDR,
// waits on the selected PREADY with a bounded timeout, and returns rdata/err
// with a one-cycle done pulse. All outputs are registered.
//
// Ports:
//   PCLK, PRESET          clock (rising edge), asynchronous active-low reset
//   req, write, addr,     host request; sampled only when idle
//   wdata
//   busy                  high from the cycle after acceptance until done
//   done, rdata, err      one-cycle completion pulse with read data / error flag
//   PADDR, PWRITE, PWDATA APB address, direction, write data (latched request)
//   PSEL, PENABLE         one-hot slave select, APB enable
//   PRDATA, PREADY        flattened per-slave read data (32 bits/slot), per-slave ready
module apb_master_bridge #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       req,
  input  logic                       write,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                rdata,
  output logic                       err,
  output logic [31:0]                PADDR,
  output logic                       PWRITE,
  output logic [NUM_SLAVES-1:0]      PSEL,
  output logic                       PENABLE,
  output logic [31:0]                PWDATA,
  input  logic [32*NUM_SLAVES-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]      PREADY
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      idx_q;
  logic            dec_err_q;

  logic [3:0]            dec_idx;
  logic                  mapped;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;

  assign dec_idx = addr[15:12];
  assign mapped  = (addr[31:16] == BASE_ADDR[31:16]) && ({28'd0, dec_idx} < NUM_SLAVES);

  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_sel[i] = mapped && (dec_idx == 4'(i));
    end
  end

  // Only the latched slot's ready/data are ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        sel_ready = PREADY[i];
        sel_rdata = PRDATA[32*i +: 32];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      dec_err_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWDATA    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            PADDR  <= addr;
            PWRITE <= write;
            PWDATA <= wdata;
            idx_q  <= dec_idx;
            busy   <= 1'b1;
            if (mapped) begin
              PSEL    <= dec_sel;
              state_q <= StSetup;
            end else begin
              // Decode error: no bus activity, complete from RESP.
              err       <= 1'b1;
              rdata     <= '0;
              dec_err_q <= 1'b1;
              state_q   <= StResp;
            end
          end
        end
        StSetup: begin
          PENABLE <= 1'b1;
          state_q <= StAccess;
        end
        StAccess: begin
          if (sel_ready) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            rdata   <= PWRITE ? 32'd0 : sel_rdata;
            err     <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt_q   <= '0;
            state_q <= StResp;
          end else if (cnt_q == CntMax) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            rdata   <= '0;
            err     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt_q   <= '0;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          cnt_q <= '0;
          if (dec_err_q) begin
            // Decode errors hold busy for one cycle before done, so the host
            // always sees busy before the completion pulse.
            dec_err_q <= 1'b0;
            err       <= 1'b1;
            rdata     <= '0;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 16;

  logic            PCLK;
  logic            PRESET;
  logic            req;
  logic            write;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            busy;
  logic            done;
  logic [31:0]     rdata;
  logic            err;
  logic [31:0]     PADDR;
  logic            PWRITE;
  logic [NS-1:0]   PSEL;
  logic            PENABLE;
  logic [31:0]     PWDATA;
  logic [32*NS-1:0] PRDATA;
  logic [NS-1:0]   PREADY;

  int n_checks;
  int n_fail;

  apb_master_bridge #(
    .NUM_SLAVES(NS),
    .BASE_ADDR (32'h1000_0000),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .req    (req),
    .write  (write),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .rdata  (rdata),
    .err    (err),
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Random noise on every slot, then the selected slot's ready/data on top.
  task automatic drive_slaves(input bit mapped, input int idx, input logic [31:0] slot,
                              input bit rdy);
    PREADY = NS'($urandom);
    for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = $urandom;
    if (mapped) begin
      PREADY[idx]          = rdy;
      PRDATA[32*idx +: 32] = slot;
    end
  endtask

  // One transfer: the selected slave raises PREADY after 'waits' low ACCESS cycles.
  // Expected timeline comes from the latency rules: done at cycle d, PSEL over 1..d-1,
  // PENABLE over 2..d-1, busy over 1..d-1, idle at d+1.
  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] slot, input bit hold);
    int          idx;
    bit          mapped;
    bit          exp_err;
    int          d;
    logic [31:0] exp_rd;
    logic [NS-1:0] exp_sel;
    idx     = int'(a[15:12]);
    mapped  = (a[31:16] == 16'h1000) && (idx < int'(NS));
    if (!mapped) d = 2;
    else if (waits < int'(TO)) d = waits + 3;
    else d = int'(TO) + 2;
    exp_err = !mapped || (waits >= int'(TO));
    exp_rd  = (!exp_err && !wr) ? slot : 32'h0;
    exp_sel = '0;
    if (mapped) exp_sel[idx] = 1'b1;

    req = 1'b1; write = wr; addr = a; wdata = wd;
    drive_slaves(mapped, idx, slot, 1'b0);
    @(posedge PCLK); #1;
    for (int c = 1; c <= d + 1; c++) begin
      if (!hold || c == d + 1) req = 1'b0;
      check("psel", 32'(PSEL), (c < d) ? 32'(exp_sel) : 32'h0);
      check("penable", 32'(PENABLE), 32'(mapped && c >= 2 && c < d));
      check("busy", 32'(busy), 32'(c < d));
      check("done", 32'(done), 32'(c == d));
      if (mapped && c < d) begin
        check("paddr", PADDR, a);
        check("pwdata", PWDATA, wd);
        check("pwrite", 32'(PWRITE), 32'(wr));
      end
      if (c == d) begin
        check("rdata", rdata, exp_rd);
        check("err", 32'(err), 32'(exp_err));
      end
      drive_slaves(mapped, idx, slot, c >= waits + 2);
      if (c <= d) begin
        @(posedge PCLK); #1;
      end
    end
  endtask

  logic [31:0] ra;
  logic [31:0] rw;
  int          rwaits;
  int          kind;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    PRESET = 1'b0; req = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    PRDATA = '0; PREADY = '0;
    #12;
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    check("rst_pwrite", 32'(PWRITE), 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge PCLK) PRESET = 1'b1;
    @(posedge PCLK); #1;

    // Zero-wait write, 3-wait read, ready on the last legal cycle.
    run_txn(1'b1, 32'h1000_1004, 32'h0000_00A5, 0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h1000_1000, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    run_txn(1'b0, 32'h1000_2000, 32'h0, 15, 32'h5A5A_A5A5, 1'b0);
    // Decode errors: slot out of range, wrong window.
    run_txn(1'b0, 32'h1000_5000, 32'h0, 0, 32'h1234_5678, 1'b0);
    run_txn(1'b1, 32'h2000_0000, 32'h55, 0, 32'h0, 1'b0);
    // Timeout on slave 2, then a normal read to slave 0.
    run_txn(1'b0, 32'h1000_2008, 32'h0, 40, 32'hCAFE_F00D, 1'b0);
    run_txn(1'b0, 32'h1000_0010, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
    // req held through busy, back-to-back.
    run_txn(1'b1, 32'h1000_3000, 32'h1111, 2, 32'h0, 1'b1);
    run_txn(1'b0, 32'h1000_3004, 32'h0, 0, 32'h2222, 1'b1);
    run_txn(1'b0, 32'h1000_6000, 32'h0, 0, 32'h0, 1'b1);
    run_txn(1'b0, 32'h1000_0000, 32'h0, 0, 32'h3333, 1'b0);

    // Reset in the middle of ACCESS.
    req = 1'b1; write = 1'b0; addr = 32'h1000_1000; wdata = 32'h0;
    drive_slaves(1'b1, 1, 32'h77, 1'b0);
    @(posedge PCLK); #1;
    req = 1'b0;
    drive_slaves(1'b1, 1, 32'h77, 1'b0);
    @(posedge PCLK); #1;
    drive_slaves(1'b1, 1, 32'h77, 1'b0);
    @(posedge PCLK); #1;
    check("pre_rst_penable", 32'(PENABLE), 32'h1);
    #3 PRESET = 1'b0;
    #1;
    check("arst_psel", 32'(PSEL), 32'h0);
    check("arst_penable", 32'(PENABLE), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_paddr", PADDR, 32'h0);
    check("arst_err", 32'(err), 32'h0);
    repeat (3) begin
      @(posedge PCLK); #1;
      check("arst_done", 32'(done), 32'h0);
      check("arst_psel_hold", 32'(PSEL), 32'h0);
    end
    @(negedge PCLK) PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("post_rst_done", 32'(done), 32'h0);
    run_txn(1'b0, 32'h1000_0020, 32'h0, 2, 32'hFACE_0001, 1'b0);

    // Randomized traffic.
    repeat (60) begin
      kind = int'($urandom_range(0, 3));
      if (kind < 3) begin
        ra = {16'h1000, 4'($urandom_range(0, NS - 1)), 12'($urandom)};
      end else if ($urandom_range(0, 1) == 0) begin
        ra = {16'h1000, 4'($urandom_range(NS, 15)), 12'($urandom)};
      end else begin
        ra = $urandom;
        if (ra[31:16] == 16'h1000) ra[31] = 1'b1;
      end
      rw     = $urandom;
      rwaits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20))
                                           : int'($urandom_range(0, 4));
      run_txn(1'($urandom), ra, rw, rwaits, $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
